instr_encoder: RTL

Sequential MIPS instruction encoder, the inverse of the single-cycle CPU's control/instruction decoder. It accepts one symbolic instruction per handshake (mnemonic index plus register, shift, immediate and target fields) and packs it into a 32-bit MIPS word. Encoded words are buffered in a FIFO and presented on a valid/ready port with a running word address, so a test-program loader can stream them into instruction memory. Every instruction the CPU decodes is covered, and each bit pattern matches what the CPU's decoder expects.

---
 rtl/instr_encoder.sv | 99 +++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic MIPS instructions into 32-bit words and streams them from a FIFO with word addresses
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int AW = 10,
    parameter logic [AW-1:0] BASE = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [5:0]                 in_op,
    input  logic [4:0]                 in_rs,
    input  logic [4:0]                 in_rt,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_shamt,
    input  logic [15:0]                in_imm,
    input  logic [25:0]                in_target,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [AW-1:0]              out_addr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err,
    output logic [5:0]                 err_op
);
    localparam int PW = $clog2(DEPTH);

    logic [5:0] code;
    logic legal, r_type, j_type, shift_op;
    logic [4:0] rs_f, rt_f, rd_f, sh_f;
    logic [31:0] word;
    logic [31:0] mem [DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    logic accept, push, pop;

    // mnemonic index to funct (R-type) or opcode (I/J-type); unmapped indices are illegal
    always_comb begin
        code = '0;
        legal = 1'b1;
        case (in_op)
            6'd0:  code = 6'h20;  6'd1:  code = 6'h21;  6'd2:  code = 6'h22;  6'd3:  code = 6'h23;
            6'd4:  code = 6'h24;  6'd5:  code = 6'h25;  6'd6:  code = 6'h26;  6'd7:  code = 6'h27;
            6'd8:  code = 6'h2A;  6'd9:  code = 6'h2B;  6'd10: code = 6'h00;  6'd11: code = 6'h02;
            6'd12: code = 6'h03;  6'd13: code = 6'h04;  6'd14: code = 6'h06;  6'd15: code = 6'h07;
            6'd16: code = 6'h08;  6'd17: code = 6'h09;  6'd18: code = 6'h08;  6'd19: code = 6'h0C;
            6'd20: code = 6'h0D;  6'd21: code = 6'h0A;  6'd22: code = 6'h0F;  6'd23: code = 6'h23;
            6'd24: code = 6'h2B;  6'd25: code = 6'h20;  6'd26: code = 6'h24;  6'd27: code = 6'h21;
            6'd28: code = 6'h25;  6'd29: code = 6'h28;  6'd30: code = 6'h29;  6'd32: code = 6'h04;
            6'd33: code = 6'h05;  6'd34: code = 6'h02;  6'd35: code = 6'h03;
            default: legal = 1'b0;
        endcase
    end

    assign r_type   = in_op <= 6'd17;
    assign j_type   = in_op == 6'd34 || in_op == 6'd35;
    assign shift_op = in_op >= 6'd10 && in_op <= 6'd12;
    assign rs_f     = (shift_op || in_op == 6'd22) ? 5'd0 : in_rs;
    assign rt_f     = (in_op == 6'd16 || in_op == 6'd17) ? 5'd0 : in_rt;
    assign rd_f     = in_op == 6'd16 ? 5'd0 : in_rd;
    assign sh_f     = shift_op ? in_shamt : 5'd0;
    assign word     = r_type ? {6'h00, rs_f, rt_f, rd_f, sh_f, code}
                    : j_type ? {code, in_target}
                    : {code, rs_f, in_rt, in_imm};

    assign count     = wr_ptr - rd_ptr;
    assign in_ready  = count != (PW+1)'(DEPTH);
    assign out_valid = count != '0;
    assign out_data  = out_valid ? mem[rd_ptr[PW-1:0]] : '0;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;

    // pointers, head address and sticky error; flush overrides any push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            out_addr <= BASE;
            err      <= 1'b0;
            err_op   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                out_addr <= out_addr + 1'b1;
            end
            if (accept && !legal) begin
                err <= 1'b1;
                if (!err) err_op <= in_op;
            end
        end
    end

    // storage needs no reset; empty entries are masked at out_data
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[PW-1:0]] <= word;
    end
endmodule
